// File: rtl/comar_and_pipe.sv
// Two-share masked AND pipeline (W independent lanes) with a reusable mask register.
// A loaded mask set serves REUSE operations; masks ride alongside their data through both stages.
module comar_and_pipe #(
    parameter int W     = 8,
    parameter int REUSE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a_s0,
    input  logic [W-1:0]     a_s1,
    input  logic [W-1:0]     b_s0,
    input  logic [W-1:0]     b_s1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6*W-1:0]   rnd,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic [W-1:0]     c_s0,
    output logic [W-1:0]     c_s1,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int UW = $clog2(REUSE + 1);
    localparam logic [UW-1:0] REUSE_U = UW'(REUSE);

    logic [6*W-1:0] mask;
    logic [UW-1:0]  uses;

    logic           en;
    logic           accept;
    logic           mask_load;

    logic [W-1:0]   r0, r1, r2, r3, r4, r5;

    // Stage 1: re-masked operand shares plus the four product masks carried with them
    logic           v1;
    logic [W-1:0]   x0, x1, y0, y1;
    logic [W-1:0]   m2, m3, m4, m5;

    // Stage 2: masked partial products and the combined mask that becomes share 1
    logic           v2;
    logic [W-1:0]   p00, p01, p10, p11;
    logic [W-1:0]   s;

    assign r0 = mask[0*W +: W];
    assign r1 = mask[1*W +: W];
    assign r2 = mask[2*W +: W];
    assign r3 = mask[3*W +: W];
    assign r4 = mask[4*W +: W];
    assign r5 = mask[5*W +: W];

    assign en        = !(v2 && !out_ready);
    assign rnd_ready = (uses == '0);
    assign in_ready  = en && (uses != '0);
    assign accept    = in_valid && in_ready;
    assign mask_load = rnd_valid && rnd_ready;

    // Loads and accepts are mutually exclusive because rnd_ready and in_ready need opposite uses values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            uses <= '0;
        end else if (mask_load) begin
            mask <= rnd;
            uses <= REUSE_U;
        end else if (accept) begin
            uses <= uses - UW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            x0 <= '0;
            x1 <= '0;
            y0 <= '0;
            y1 <= '0;
            m2 <= '0;
            m3 <= '0;
            m4 <= '0;
            m5 <= '0;
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                x0 <= a_s0 ^ r0;
                x1 <= a_s1 ^ r0;
                y0 <= b_s0 ^ r1;
                y1 <= b_s1 ^ r1;
                m2 <= r2;
                m3 <= r3;
                m4 <= r4;
                m5 <= r5;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            p00 <= '0;
            p01 <= '0;
            p10 <= '0;
            p11 <= '0;
            s   <= '0;
        end else if (en) begin
            v2  <= v1;
            p00 <= (x0 & y0) ^ m2;
            p01 <= (x0 & y1) ^ m3;
            p10 <= (x1 & y0) ^ m4;
            p11 <= (x1 & y1) ^ m5;
            s   <= m2 ^ m3 ^ m4 ^ m5;
        end
    end

    assign c_s0      = p00 ^ p01 ^ p10 ^ p11;
    assign c_s1      = s;
    assign out_valid = v2;

endmodule

// File: tb/tb_comar_and_pipe.sv
// Directed bench for comar_and_pipe (W=4, REUSE=2) with hand-computed expected shares.
module tb_comar_and_pipe;

    localparam int W     = 4;
    localparam int REUSE = 2;

    logic             clk;
    logic             rst;
    logic [W-1:0]     a_s0, a_s1, b_s0, b_s1;
    logic             in_valid;
    logic             in_ready;
    logic [6*W-1:0]   rnd;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [W-1:0]     c_s0, c_s1;
    logic             out_valid;
    logic             out_ready;

    int checks;
    int failures;

    comar_and_pipe #(.W(W), .REUSE(REUSE)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_s0      (a_s0),
        .a_s1      (a_s1),
        .b_s0      (b_s0),
        .b_s1      (b_s1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .c_s0      (c_s0),
        .c_s1      (c_s1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual[W-1:0], expected[W-1:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6*W-1:0] packMask(input logic [W-1:0] r0, r1, r2, r3, r4, r5);
        return {r5, r4, r3, r2, r1, r0};
    endfunction

    task automatic applyStimulus(input logic [W-1:0] as0, as1, bs0, bs1, input logic valid);
        a_s0     = as0;
        a_s1     = as1;
        b_s0     = bs0;
        b_s1     = bs1;
        in_valid = valid;
    endtask

    task automatic loadMask(input logic [6*W-1:0] value);
        rnd       = value;
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_c_s0"}, 32'(c_s0), 32'(e0));
        checkOutput({tag, "_c_s1"}, 32'(c_s1), 32'(e1));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        rnd       = '0;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_c_s0", 32'(c_s0), 32'd0);
        checkOutput("rst_c_s1", 32'(c_s1), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_rnd_ready", 32'(rnd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Zero masks: plain AND of the recombined operands
        loadMask(packMask(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        checkOutput("load0_in_ready", 32'(in_ready), 32'd1);
        checkOutput("load0_rnd_ready", 32'(rnd_ready), 32'd0);
        applyStimulus(4'b1010, 4'b0000, 4'b1100, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lat1_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkResult("zero_mask", 4'b1000, 4'b0000);
        tick();
        checkOutput("zero_mask_drain", 32'(out_valid), 32'd0);

        applyStimulus(4'b0110, 4'b0011, 4'b1111, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("used_in_ready", 32'(in_ready), 32'd0);
        checkOutput("used_rnd_ready", 32'(rnd_ready), 32'd1);
        tick();
        checkResult("zero_mask_b", 4'b0101, 4'b0000);

        // r2 = 1111 only: back-to-back pair, results on consecutive cycles
        loadMask(packMask(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0));
        applyStimulus(4'b1010, 4'b0000, 4'b1100, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b1111, 4'b0101, 4'b0011, 4'b0101, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkResult("r2_mask_a", 4'b0111, 4'b1111);
        checkOutput("r2_mask_a_recombined", 32'(c_s0 ^ c_s1), 32'b1000);
        tick();
        checkResult("r2_mask_b", 4'b1101, 4'b1111);
        tick();
        checkOutput("r2_drain", 32'(out_valid), 32'd0);

        // Three ops against a REUSE of two, with a reload while op Y is still in stage 1
        loadMask(packMask(4'b0101, 4'b0011, 4'b1001, 4'b0110, 4'b1111, 4'b0001));
        applyStimulus(4'b1100, 4'b0110, 4'b1011, 4'b0010, 1'b1);
        checkOutput("x_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(4'b0001, 4'b1110, 4'b0101, 4'b0000, 1'b1);
        checkOutput("y_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkResult("op_x", 4'b1001, 4'b0001);
        applyStimulus(4'b0111, 4'b0100, 4'b1110, 4'b1001, 1'b1);
        checkOutput("z_blocked_in_ready", 32'(in_ready), 32'd0);
        checkOutput("z_blocked_rnd_ready", 32'(rnd_ready), 32'd1);
        loadMask(packMask(4'b1111, 4'b1010, 4'b0011, 4'b0101, 4'b0000, 4'b1000));
        checkResult("op_y_after_reload", 4'b0100, 4'b0001);
        checkOutput("z_after_load_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("z_gap_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkResult("op_z", 4'b1101, 4'b1110);

        applyStimulus(4'b1000, 4'b0000, 4'b1000, 4'b1111, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkResult("op_p", 4'b1110, 4'b1110);

        // Backpressure with two ops in flight
        loadMask(packMask(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        out_ready = 1'b0;
        applyStimulus(4'b0011, 4'b0101, 4'b1110, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b1010, 4'b0101, 4'b1111, 4'b0000, 1'b1);
        checkResult("stall_q", 4'b0110, 4'b0000);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkResult("stall_q_hold1", 4'b0110, 4'b0000);
        tick();
        checkResult("stall_q_hold2", 4'b0110, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        out_ready = 1'b1;
        tick();
        checkResult("release_r", 4'b0001, 4'b0000);
        tick();
        checkOutput("release_drain", 32'(out_valid), 32'd0);

        // Reset with two ops in flight
        loadMask(packMask(4'b0101, 4'b0011, 4'b1001, 4'b0110, 4'b1111, 4'b0001));
        applyStimulus(4'b1100, 4'b0110, 4'b1011, 4'b0010, 1'b1);
        tick();
        applyStimulus(4'b0001, 4'b1110, 4'b0101, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_c_s0", 32'(c_s0), 32'd0);
        checkOutput("mid_rst_rnd_ready", 32'(rnd_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_rnd_ready", 32'(rnd_ready), 32'd1);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
